// File: rtl/rtc_bus_pkg.sv
// Shared types and default timing for the RTC multiplexed-bus controller.
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StASu,
    StAPw,
    StAHd,
    StARec,
    StDSu,
    StDPw,
    StDHd,
    StDRec
  } rtc_state_t;

  localparam int unsigned RTC_T_SU  = 2;
  localparam int unsigned RTC_T_PW  = 10;
  localparam int unsigned RTC_T_HD  = 2;
  localparam int unsigned RTC_T_REC = 5;

  localparam logic RTC_OP_RD = 1'b0;
  localparam logic RTC_OP_WR = 1'b1;

  function automatic int unsigned max4(int unsigned a, int unsigned b, int unsigned c,
                                       int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/rtc_bus_ctrl_if.sv
// RTC chip pin bundle: the controller is the master, the RTC device the slave.
interface rtc_bus_ctrl_if;
  logic       rtc_cs_n;
  logic       rtc_rd_n;
  logic       rtc_wr_n;
  logic       rtc_ad;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;

  modport master (
    output rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad, ad_out, ad_oe,
    input  ad_in
  );

  modport slave (
    input  rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad, ad_out, ad_oe,
    output ad_in
  );
endinterface

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing each bus-cycle state; done flags the last cycle.
module rtc_phase_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] len,
  output logic             done
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = len;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == Width'(1));

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Runs one address+data multiplexed bus cycle on the RTC pins per processor port access.
// Optional one-entry pending buffer enabled by defining RTC_BUS_CTRL_PEND_EN.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_SU  = RTC_T_SU,
  parameter int unsigned T_PW  = RTC_T_PW,
  parameter int unsigned T_HD  = RTC_T_HD,
  parameter int unsigned T_REC = RTC_T_REC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  act_rtc,
  input  logic [7:0]            dir,
  input  logic                  wr_strobe,
  input  logic                  rd_strobe,
  input  logic [7:0]            dato_wr,
  output logic                  ready,
  output logic                  busy,
  output logic [7:0]            dato_rd,
  output logic                  rd_valid,
  output logic                  ovf,
  rtc_bus_ctrl_if.master        bus
);

  localparam int unsigned TMax = max4(T_SU, T_PW, T_HD, T_REC);
  localparam int unsigned TW   = $clog2(TMax + 1);

  rtc_state_t state_q, state_d;
  logic       op_q, op_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0] dato_rd_q, dato_rd_d;
  logic       rd_valid_q, rd_valid_d, ovf_q, ovf_d;
  logic       cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, ad_q, ad_d;
  logic       oe_q, oe_d;
  logic [7:0] out_q, out_d;

  logic          req, req_op, accept;
  logic          tmr_load, tmr_done;
  logic [TW-1:0] tmr_len;

  assign req    = (wr_strobe | rd_strobe) & act_rtc;
  assign req_op = wr_strobe ? RTC_OP_WR : RTC_OP_RD;
  assign accept = req & ready;
  assign busy   = (state_q != StIdle);

`ifdef RTC_BUS_CTRL_PEND_EN
  logic       pend_valid_q, pend_valid_d, pend_op_q, pend_op_d;
  logic [7:0] pend_addr_q, pend_addr_d, pend_wdata_q, pend_wdata_d;

  assign ready = !pend_valid_q;
`else
  assign ready = (state_q == StIdle);
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    dato_rd_d  = dato_rd_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q | (req & ~ready);
`ifdef RTC_BUS_CTRL_PEND_EN
    pend_valid_d = pend_valid_q;
    pend_op_d    = pend_op_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StASu;
          op_d    = req_op;
          addr_d  = dir;
          wdata_d = dato_wr;
        end
      end
      StASu:  if (tmr_done) state_d = StAPw;
      StAPw:  if (tmr_done) state_d = StAHd;
      StAHd:  if (tmr_done) state_d = StARec;
      StARec: if (tmr_done) state_d = StDSu;
      StDSu:  if (tmr_done) state_d = StDPw;
      StDPw: begin
        if (tmr_done) begin
          state_d = StDHd;
          if (op_q == RTC_OP_RD) begin
            dato_rd_d  = bus.ad_in;
            rd_valid_d = 1'b1;
          end
        end
      end
      StDHd:  if (tmr_done) state_d = StDRec;
      StDRec: begin
        if (tmr_done) begin
          state_d = StIdle;
`ifdef RTC_BUS_CTRL_PEND_EN
          // Chain straight into the next cycle, skipping IDLE.
          if (pend_valid_q) begin
            state_d      = StASu;
            op_d         = pend_op_q;
            addr_d       = pend_addr_q;
            wdata_d      = pend_wdata_q;
            pend_valid_d = 1'b0;
          end else if (accept) begin
            state_d = StASu;
            op_d    = req_op;
            addr_d  = dir;
            wdata_d = dato_wr;
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef RTC_BUS_CTRL_PEND_EN
    if (accept && busy && !(state_q == StDRec && tmr_done)) begin
      pend_valid_d = 1'b1;
      pend_op_d    = req_op;
      pend_addr_d  = dir;
      pend_wdata_d = dato_wr;
    end
`endif
  end

  assign tmr_load = (state_d != state_q);

  always_comb begin
    tmr_len = '0;
    unique case (state_d)
      StASu, StDSu:   tmr_len = TW'(T_SU);
      StAPw, StDPw:   tmr_len = TW'(T_PW);
      StAHd, StDHd:   tmr_len = TW'(T_HD);
      StARec, StDRec: tmr_len = TW'(T_REC);
      default:        tmr_len = '0;
    endcase
  end

  // Pins are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    cs_n_d = 1'b1;
    rd_n_d = 1'b1;
    wr_n_d = 1'b1;
    ad_d   = 1'b1;
    oe_d   = 1'b0;
    out_d  = 8'h00;
    unique case (state_d)
      StASu, StAPw, StAHd: begin
        cs_n_d = 1'b0;
        ad_d   = 1'b0;
        oe_d   = 1'b1;
        out_d  = addr_d;
        if (state_d == StAPw) wr_n_d = 1'b0;
      end
      StDSu, StDPw, StDHd: begin
        cs_n_d = 1'b0;
        if (op_d == RTC_OP_WR) begin
          oe_d  = 1'b1;
          out_d = wdata_d;
        end
        if (state_d == StDPw) begin
          if (op_d == RTC_OP_WR) wr_n_d = 1'b0;
          else                   rd_n_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= RTC_OP_RD;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      dato_rd_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      ad_q       <= 1'b1;
      oe_q       <= 1'b0;
      out_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dato_rd_q  <= dato_rd_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      cs_n_q     <= cs_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      ad_q       <= ad_d;
      oe_q       <= oe_d;
      out_q      <= out_d;
    end
  end

`ifdef RTC_BUS_CTRL_PEND_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_op_q    <= RTC_OP_RD;
      pend_addr_q  <= 8'h00;
      pend_wdata_q <= 8'h00;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_op_q    <= pend_op_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
    end
  end
`endif

  rtc_phase_timer #(
    .Width (TW)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .len   (tmr_len),
    .done  (tmr_done)
  );

  assign dato_rd      = dato_rd_q;
  assign rd_valid     = rd_valid_q;
  assign ovf          = ovf_q;
  assign bus.rtc_cs_n = cs_n_q;
  assign bus.rtc_rd_n = rd_n_q;
  assign bus.rtc_wr_n = wr_n_q;
  assign bus.rtc_ad   = ad_q;
  assign bus.ad_oe    = oe_q;
  assign bus.ad_out   = out_q;

endmodule

// File: doc/rtc_bus_ctrl.md
# rtc_bus_ctrl

Device-side executor for the processor's port accesses to the real-time clock. The port decoder turns a port ID into `act_rtc` plus an 8-bit RTC register address `dir`. This block takes that select, the processor read/write strobes and the write data, and runs one complete Intel-style multiplexed address/data bus cycle on the RTC chip pins. On reads it returns the register byte to the processor's input-port mux with a one-cycle valid pulse.

## Interface
- `T_SU`, default 2: setup cycles before each strobe (≥1)
- `T_PW`, default 10: strobe low width in cycles (≥1)
- `T_HD`, default 2: hold cycles after each strobe (≥1)
- `T_REC`, default 5: idle cycles after each phase, all pins deasserted (≥1)
- `clk`  in  1  system clock, single domain
- `rst_n`  in  1  asynchronous, active-low reset
- `act_rtc`  in  1  RTC selected by the port decoder
- `dir`  in  8  RTC register address from the port decoder
- `wr_strobe`  in  1  processor write strobe, one cycle
- `rd_strobe`  in  1  processor read strobe, one cycle
- `dato_wr`  in  8  processor write data
- `ready`  out  1  a request is accepted this cycle if a strobe arrives
- `busy`  out  1  FSM not in IDLE
- `dato_rd`  out  8  last byte read from the RTC, held until the next read completes
- `rd_valid`  out  1  one-cycle pulse when `dato_rd` updates
- `ovf`  out  1  sticky; a request arrived while `ready`=0; cleared only by reset
- `rtc_cs_n`, `rtc_rd_n`, `rtc_wr_n`  out  1 each  RTC chip select, read strobe, write strobe (active-low)
- `rtc_ad`  out  1  0 = address phase, 1 = data phase
- `ad_out`  out  8  bus drive value
- `ad_oe`  out  1  tristate enable for `ad_out`
- `ad_in`  in  8  bus sample value

## Operation
- Request = (`wr_strobe` | `rd_strobe`) & `act_rtc`. Strobes with `act_rtc`=0 are ignored.
- If both strobes are high, the write wins.
- Accepted request: `dir`, `dato_wr` and the op type are latched on the accepting edge.
- Request while `ready`=0: no cycle is run, and `ovf` is set.
- FSM states: IDLE → A_SU → A_PW → A_HD → A_REC → D_SU → D_PW → D_HD → D_REC → IDLE. Each non-IDLE state lasts exactly its parameter in cycles.
- Address phase:
  - A_SU: `rtc_cs_n`=0, `rtc_ad`=0, `ad_oe`=1, `ad_out`=`dir`.
  - A_PW: additionally `rtc_wr_n`=0.
  - A_HD: `rtc_wr_n`=1 while cs, ad and bus are held.
  - A_REC: `rtc_cs_n`=1, `ad_oe`=0, `rtc_ad`=1.
- Data phase:
  - D_SU: `rtc_cs_n`=0, `rtc_ad`=1. On a write, `ad_oe`=1 and `ad_out`=`dato_wr`; on a read, `ad_oe`=0.
  - D_PW: `rtc_wr_n`=0 for a write, or `rtc_rd_n`=0 for a read.
  - D_HD: strobe released.
  - D_REC: all deasserted.
- Read capture: `ad_in` is registered into `dato_rd` on the edge that ends the last D_PW cycle. `rd_valid`=1 during the first D_HD cycle.
- `ready` = (state==IDLE) unless the feature below is enabled.
- Reset mid-cycle: all pins return to idle immediately and the latched request is discarded.

## Timing
- Reset values:
  - `rtc_cs_n`=`rtc_rd_n`=`rtc_wr_n`=1, `rtc_ad`=1.
  - `ad_oe`=0, `ad_out`=0, `dato_rd`=0.
  - `rd_valid`=0, `ovf`=0, `busy`=0, `ready`=1.
- All outputs are registered except `ready`/`busy`, which decode the state register.
- Accept edge to first A_SU cycle: 1 cycle.
- Accept edge to IDLE: 2·(T_SU+T_PW+T_HD+T_REC) cycles, 38 with the defaults.
- Phase timer width: $clog2(max parameter + 1). The count loads at each state entry and the state advances when the count reaches 1.
- A back-to-back request is accepted in the first IDLE cycle after D_REC.

## Configuration
- `RTC_BUS_CTRL_PEND_EN` defined: one-entry pending buffer.
  - `ready` = !pend_valid.
  - A request during `busy` is stored and starts on the cycle after D_REC ends, with no IDLE cycle in between.
  - `ovf` is set only when the buffer is full.
- `RTC_BUS_CTRL_PEND_EN` undefined: no buffer, and the behaviour is as in Operation.

## Structure
- Package `rtc_bus_pkg`:
  - state enum `rtc_state_t`
  - default timing constants `RTC_T_SU`/`RTC_T_PW`/`RTC_T_HD`/`RTC_T_REC`
  - op encoding `RTC_OP_RD`/`RTC_OP_WR`
- Sub-module `rtc_phase_timer`: loadable down-counter with `load`, `len` and a `done` output. One instance is shared by all states.

## Test plan
- Write `dir`=8'h21, `dato_wr`=8'h59 → address phase drives 21 with `rtc_wr_n` low for 10 cycles; data phase drives 59 with `rtc_wr_n` low for 10 cycles; `busy` lasts 38 cycles; `rd_valid` never pulses.
- Read `dir`=8'h43 with `ad_in`=8'h12 during D_PW → `dato_rd`=8'h12, `rd_valid` high for exactly one cycle in D_HD, `ad_oe`=0 throughout the data phase.
- Strobe with `act_rtc`=0 → no pin activity, `ovf` stays 0. Both strobes high → a write cycle runs.
- Second write at cycle 5 of a cycle:
  - macro off: dropped, and `ovf`=1.
  - macro on: runs immediately after the first cycle's D_REC, and `ovf`=0. A third request during that window sets `ovf`.
- `rst_n` low during A_PW → all pins are idle in the same cycle, no further strobes, `busy`=0 after release.
- Parameters T_SU=T_PW=T_HD=T_REC=1 → full cycle is 8 cycles and every pin sequence is still correct.
